// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - dmType encodings, external FSM states and helpers for dm_arbiter
package dm_arbiter_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } ext_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - CPU byte-lane steering, load extension and misalignment decode
module dm_lane
    import dm_arbiter_pkg::*;
(
    input  logic        act,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmtype,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic        is_half;
    logic        is_byte;
    logic [31:0] shifted;
    logic        unused_shifted;

    assign is_half        = (dmtype == DM_HALF) || (dmtype == DM_HALF_U);
    assign is_byte        = (dmtype == DM_BYTE) || (dmtype == DM_BYTE_U);
    assign shifted        = rdata >> {addr_lo, 3'b000};
    assign unused_shifted = ^shifted[31:16];

    // Unknown encodings fall through to word handling.
    assign misalign = act & ((is_half & addr_lo[0]) |
                             (!is_half & !is_byte & (addr_lo != 2'b00)));

    always_comb begin
        be            = 4'b1111;
        wdata_steered = wdata;
        rdata_ext     = rdata;
        if (is_byte) begin
            be            = 4'b0001 << addr_lo;
            wdata_steered = {4{wdata[7:0]}};
            rdata_ext     = (dmtype == DM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                                : {24'b0, shifted[7:0]};
        end else if (is_half) begin
            be            = 4'b0011 << addr_lo;
            wdata_steered = {2{wdata[15:0]}};
            rdata_ext     = (dmtype == DM_HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                                                : {16'b0, shifted[15:0]};
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory port sharing between the CPU (priority) and an external requester
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_mem_w,
    input  logic              cpu_mem_r,
    input  logic [2:0]        cpu_dmtype,
    output logic [31:0]       cpu_rdata,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    input  logic [3:0]        ext_be,
    output logic              ext_ready,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              ext_starved,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] STARVE_CNT = 8'(STARVE_LIMIT);

    ext_state_t        state;
    ext_state_t        state_next;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;
    logic [7:0]        wait_cnt;

    logic              cpu_act;
    logic              grant;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              misalign;
    logic              unused_addr;

    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    assign cpu_act     = cpu_mem_w | cpu_mem_r;
    assign grant       = (state == ST_PEND) && !cpu_act;
    assign ext_ready   = (state == ST_DONE);
    assign ext_rvalid  = (state == ST_DONE) && !cap_we;
    assign ext_starved = (state == ST_PEND) && (wait_cnt >= STARVE_CNT);

    dm_lane u_lane (
        .act           (cpu_act),
        .addr_lo       (cpu_addr[1:0]),
        .dmtype        (cpu_dmtype),
        .wdata         (cpu_wdata),
        .rdata         (mem_rdata),
        .be            (lane_be),
        .wdata_steered (lane_wdata),
        .rdata_ext     (lane_rdata),
        .misalign      (misalign)
    );

    // CPU owns the port whenever it is active; the external side only gets leftover cycles.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'b0;
        cpu_rdata = 32'b0;
        if (cpu_act) begin
            mem_addr  = cpu_addr[ADDR_W+1:2];
            mem_wdata = lane_wdata;
            if (!misalign) begin
                mem_we    = cpu_mem_w;
                mem_be    = lane_be;
                cpu_rdata = lane_rdata;
            end
        end else if (grant) begin
            mem_addr  = cap_addr;
            mem_we    = cap_we;
            mem_be    = cap_be;
            mem_wdata = cap_wdata;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ext_valid) state_next = ST_PEND;
            ST_PEND: if (grant)     state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'b0;
            cap_be       <= 4'b0000;
            wait_cnt     <= 8'd0;
            ext_rdata    <= 32'b0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && ext_valid) begin
                cap_we    <= ext_we;
                cap_addr  <= ext_addr[ADDR_W+1:2];
                cap_wdata <= ext_wdata;
                cap_be    <= ext_be;
                wait_cnt  <= 8'd0;
            end
            if (state == ST_PEND && !grant)
                wait_cnt <= sat_inc8(wait_cnt);
            if (grant && !cap_we)
                ext_rdata <= mem_rdata;
            if (misalign)
                misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_mem_w;
    logic        cpu_mem_r;
    logic [2:0]  cpu_dmtype;
    logic [31:0] cpu_rdata;
    logic        ext_valid;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_be;
    logic        ext_ready;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ext_starved;
    logic        misalign_err;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] exp_q [$];
    int          n_checks;
    int          n_fail;

    dm_arbiter #(.ADDR_W(8), .STARVE_LIMIT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_mem_w    (cpu_mem_w),
        .cpu_mem_r    (cpu_mem_r),
        .cpu_dmtype   (cpu_dmtype),
        .cpu_rdata    (cpu_rdata),
        .ext_valid    (ext_valid),
        .ext_we       (ext_we),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_be       (ext_be),
        .ext_ready    (ext_ready),
        .ext_rvalid   (ext_rvalid),
        .ext_rdata    (ext_rdata),
        .ext_starved  (ext_starved),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[0]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
            if (mem_be[2]) mem[mem_addr][23:16] <= mem_wdata[23:16];
            if (mem_be[3]) mem[mem_addr][31:24] <= mem_wdata[31:24];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_mem_w  = 1'b0;
        cpu_mem_r  = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_dmtype = 3'b000;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (ext_ready !== 1'b0 || ext_rvalid !== 1'b0 || ext_starved !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ext_flags: ready=%b rvalid=%b starved=%b, required 0 0 0",
                     ext_ready, ext_rvalid, ext_starved);
        end
        n_checks++;
        if (ext_rdata !== 32'h0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: ext_rdata=%h misalign_err=%b, required 0 0", ext_rdata, misalign_err);
        end
        n_checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle_port: we=%b be=%h addr=%h wdata=%h rdata=%h, required all zero",
                     mem_we, mem_be, mem_addr, mem_wdata, cpu_rdata);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_cpu_store_byte();
        step();
        cpu_mem_w  = 1'b1;
        cpu_addr   = 32'h0000_0006;
        cpu_wdata  = 32'h0000_00AB;
        cpu_dmtype = 3'b011;
        @(negedge clk);
        n_checks++;
        if (mem_be !== 4'b0100 || mem_wdata !== 32'hABAB_ABAB || mem_addr !== 8'd1 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL store_byte_port: be=%b wdata=%h addr=%0d we=%b, required 0100 ababab ab 1 1",
                     mem_be, mem_wdata, mem_addr, mem_we);
        end
        step();
        cpu_idle();
        @(negedge clk);
        n_checks++;
        if (mem[1] !== 32'h10AB_0001) begin
            n_fail++;
            $display("FAIL store_byte_commit: mem[1]=%h, required 10ab0001", mem[1]);
        end
        n_checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_port: we=%b be=%h addr=%h wdata=%h rdata=%h, required all zero",
                     mem_we, mem_be, mem_addr, mem_wdata, cpu_rdata);
        end
    endtask

    task automatic test_cpu_loads();
        logic [2:0]  types [3];
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        logic [31:0] e;
        types = '{3'b001, 3'b010, 3'b011};
        addrs = '{32'h2, 32'h2, 32'h3};
        exps  = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80};
        for (int i = 0; i < 3; i++) begin
            step();
            cpu_mem_r  = 1'b1;
            cpu_addr   = addrs[i];
            cpu_dmtype = types[i];
            exp_q.push_back(exps[i]);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (cpu_rdata !== e) begin
                    n_fail++;
                    $display("FAIL load_%0d: cpu_rdata=%h, required %h", i, cpu_rdata, e);
                end
            end
        end
        step();
        cpu_idle();
    endtask

    task automatic ext_read(input logic [31:0] addr, input logic [31:0] expv, input string name);
        int          lat;
        logic [31:0] e;
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = addr;
        ext_be    = 4'hF;
        exp_q.push_back(expv);
        lat = 0;
        @(negedge clk);
        while (!ext_ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL %s_latency: ready after %0d cycles, required 2", name, lat);
        end
        n_checks++;
        if (ext_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_rvalid: rvalid=%b, required 1", name, ext_rvalid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_data: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if (ext_rdata !== e) begin
                n_fail++;
                $display("FAIL %s_data: ext_rdata=%h, required %h", name, ext_rdata, e);
            end
        end
        step();
    endtask

    task automatic test_ext_read();
        step();
        ext_read(32'h10, 32'h1000_0004, "ext_read");
        ext_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ext_ready !== 1'b0 || ext_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_read_pulse: ready=%b rvalid=%b one cycle later, required 0 0", ext_ready, ext_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        step();
        ext_read(32'h14, 32'h1000_0005, "b2b_first");
        ext_read(32'h1B, 32'h1000_0006, "b2b_second");
        ext_valid = 1'b0;
    endtask

    task automatic test_starvation();
        step();
        ext_valid  = 1'b1;
        ext_we     = 1'b1;
        ext_addr   = 32'h20;
        ext_wdata  = 32'h1234_5678;
        ext_be     = 4'hF;
        cpu_mem_r  = 1'b1;
        cpu_addr   = 32'h0;
        cpu_dmtype = 3'b000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (mem_we !== 1'b0 || ext_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_no_grant_%0d: mem_we=%b ready=%b, required 0 0", k, mem_we, ext_ready);
            end
            n_checks++;
            if (ext_starved !== (k >= 17)) begin
                n_fail++;
                $display("FAIL starve_flag_%0d: ext_starved=%b, required %b", k, ext_starved, (k >= 17));
            end
            step();
        end
        cpu_idle();
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd8 || mem_be !== 4'hF || mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL starve_grant: we=%b addr=%0d be=%h wdata=%h, required 1 8 f 12345678",
                     mem_we, mem_addr, mem_be, mem_wdata);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (ext_ready !== 1'b1 || ext_rvalid !== 1'b0 || mem[8] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL starve_done: ready=%b rvalid=%b mem[8]=%h, required 1 0 12345678",
                     ext_ready, ext_rvalid, mem[8]);
        end
        step();
        ext_valid = 1'b0;
    endtask

    task automatic test_misalign();
        step();
        cpu_mem_w  = 1'b1;
        cpu_addr   = 32'h5;
        cpu_wdata  = 32'hFFFF_FFFF;
        cpu_dmtype = 3'b000;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'h0 || cpu_rdata !== 32'h0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_suppress: we=%b be=%h rdata=%h err=%b, required 0 0 0 0",
                     mem_we, mem_be, cpu_rdata, misalign_err);
        end
        step();
        cpu_idle();
        @(negedge clk);
        n_checks++;
        if (misalign_err !== 1'b1 || mem[1] !== 32'h10AB_0001) begin
            n_fail++;
            $display("FAIL misalign_set: err=%b mem[1]=%h, required 1 10ab0001", misalign_err, mem[1]);
        end
        step();
        cpu_mem_r = 1'b1;
        repeat (3) step();
        cpu_idle();
        @(negedge clk);
        n_checks++;
        if (misalign_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_sticky: err=%b, required 1", misalign_err);
        end
    endtask

    task automatic test_reset_mid_op();
        int ready_seen;
        step();
        ext_valid  = 1'b1;
        ext_we     = 1'b1;
        ext_addr   = 32'h24;
        ext_wdata  = 32'hDEAD_BEEF;
        ext_be     = 4'hF;
        cpu_mem_r  = 1'b1;
        repeat (2) step();
        reset     = 1'b0;
        ext_valid = 1'b0;
        cpu_idle();
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0 || ext_ready !== 1'b0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: we=%b ready=%b err=%b, required 0 0 0", mem_we, ext_ready, misalign_err);
        end
        step();
        reset = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ext_ready === 1'b1 || mem_we === 1'b1) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0 || mem[9] !== 32'h1000_0009) begin
            n_fail++;
            $display("FAIL reset_discard: ready/write cycles=%0d mem[9]=%h, required 0 10000009",
                     ready_seen, mem[9]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h8001_1234;
        reset     = 1'b0;
        ext_valid = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = 32'h0;
        ext_wdata = 32'h0;
        ext_be    = 4'h0;
        cpu_idle();
        test_reset();
        test_cpu_store_byte();
        test_cpu_loads();
        test_ext_read();
        test_back_to_back();
        test_starvation();
        test_misalign();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
